// File: rtl/seq_alu_if.sv
// seq_alu_if: operand-issue and result handshake bundle for seq_alu
interface seq_alu_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       sel;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             Cout;
    logic             Negative;
    logic             Zero;
    logic             Overflow;
    modport master (
        output in_valid, A, B, sel, Cin, out_ready,
        input  in_ready, out_valid, Y, Cout, Negative, Zero, Overflow
    );
    modport slave (
        input  in_valid, A, B, sel, Cin, out_ready,
        output in_ready, out_valid, Y, Cout, Negative, Zero, Overflow
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshake and iterative shift-add multiplier
module seq_alu #(parameter int WIDTH = 32) (
    input logic      clk,
    input logic      rst,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t             state;
    logic [2*WIDTH-1:0] acc, mcand, acc_n;
    logic [WIDTH-1:0]   mplier, res, bx;
    logic [WIDTH:0]     sum;
    logic [CW-1:0]      cnt;
    logic [SHW-1:0]     sh;
    logic               cx, arith, c, v, accept;
    assign bus.in_ready = state == IDLE && !rst;
    assign accept = bus.in_valid && bus.in_ready;
    assign acc_n = mplier[0] ? acc + mcand : acc;
    always_comb begin
        sh = bus.B[SHW-1:0];
        bx = bus.sel == 4'h6 ? ~bus.B : bus.B;
        cx = bus.sel == 4'h6 ? 1'b1 : bus.Cin;
        sum = {1'b0, bus.A} + {1'b0, bx} + {{WIDTH{1'b0}}, cx};
        arith = bus.sel == 4'h5 || bus.sel == 4'h6;
        c = arith && sum[WIDTH];
        v = arith && (bus.A[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
        res = '0;
        case (bus.sel)
            4'h0: res = bus.A & bus.B;
            4'h1: res = bus.A | bus.B;
            4'h2: res = bus.A ^ bus.B;
            4'h3: res = ~(bus.A | bus.B);
            4'h4: res = ~bus.A;
            4'h5, 4'h6: res = sum[WIDTH-1:0];
            4'h7: res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            4'h8: res = bus.A << sh;
            4'h9: res = bus.A >> sh;
            4'hA: res = $unsigned($signed(bus.A) >>> sh);
            default: res = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus.out_valid <= 1'b0;
            bus.Y <= '0;
            bus.Cout <= 1'b0;
            bus.Negative <= 1'b0;
            bus.Zero <= 1'b0;
            bus.Overflow <= 1'b0;
            cnt <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (bus.sel == 4'hB) begin
                        state <= BUSY;
                        cnt <= '0;
                        acc <= '0;
                        mcand <= {{WIDTH{1'b0}}, bus.A};
                        mplier <= bus.B;
                    end else begin
                        state <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.Y <= res;
                        bus.Cout <= c;
                        bus.Negative <= res[WIDTH-1];
                        bus.Zero <= res == '0;
                        bus.Overflow <= v;
                    end
                end
                BUSY: begin
                    acc <= acc_n;
                    mcand <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.Y <= acc_n[WIDTH-1:0];
                        bus.Cout <= 1'b0;
                        bus.Negative <= acc_n[WIDTH-1];
                        bus.Zero <= acc_n[WIDTH-1:0] == '0;
                        bus.Overflow <= |acc_n[2*WIDTH-1:WIDTH];
                    end
                end
                DONE: if (bus.out_ready) begin
                    state <= IDLE;
                    bus.out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered ALU. Successor to the combinational 32-bit ALU: WIDTH is generic, results and flags are registered, and a valid/ready handshake sits on both sides. Adds shifts, signed set-less-than, and an iterative shift-add multiplier that takes WIDTH cycles. Sits between the operand-issue logic and the writeback stage of the datapath.

Parameters:
WIDTH, 32, operand/result width in bits; must be at least 4.
SHW, $clog2(WIDTH), width of the shift-amount field taken from B[SHW-1:0]; derived, never overridden.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand/op presented.
in_ready  output  1  block can accept; high only in IDLE and rst low.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B; low SHW bits are the shift amount for shifts.
sel  input  4  opcode.
Cin  input  1  carry-in, used by ADD only.
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer takes the result.
Y  output  WIDTH  result (registered).
Cout  output  1  carry flag (registered).
Negative  output  1  Y[WIDTH-1] (registered).
Zero  output  1  Y == 0 (registered).
Overflow  output  1  overflow flag (registered).

Behaviour:
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NOT A, 5 ADD (A+B+Cin), 6 SUB (A+~B+1, Cin ignored), 7 SLT (signed A<B gives 1, else 0), 8 SLL, 9 SRL, A SRA, B MUL (unsigned, low WIDTH bits), C-F reserved.
- Reserved opcodes: Y=0, Zero=1, other flags 0, latency 1.
- FSM states:
  - IDLE: in_ready=1. On in_valid, the op is accepted at the clock edge. A non-MUL op goes to DONE. MUL goes to BUSY with step count 0.
  - BUSY: one multiplier bit per edge. After WIDTH step edges, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE at the next edge.
- in_ready is 0 in BUSY and DONE. An op is never accepted in the same cycle a result is consumed.
- Latency:
  - Non-MUL: result registered on the accept edge; out_valid=1 in the following cycle.
  - MUL: out_valid=1 exactly WIDTH+1 cycles after the accept cycle.
- Operands (A, B, sel, Cin) are captured on the accept edge. Later input changes do not affect an in-flight op.
- Flags:
  - ADD/SUB: Cout = carry out of bit WIDTH-1 (SUB: 1 = no borrow). Overflow = signed overflow (operand signs equal and result sign differs, using ~B for SUB).
  - MUL: Cout=0. Overflow=1 if the upper WIDTH bits of the 2*WIDTH product are nonzero.
  - All other ops: Cout=0, Overflow=0.
  - All ops: Negative=Y[WIDTH-1], Zero=(Y==0).
- Shifts:
  - Amount is B[SHW-1:0]; upper B bits are ignored.
  - SRA replicates A[WIDTH-1].
  - An amount of 0 passes A through.
- Backpressure: while out_valid=1 and out_ready=0, Y and all flags hold stable.
- Y and flags keep their last value after consumption; they are meaningful only while out_valid=1.
- Reset (synchronous):
  - State goes to IDLE; Y, Cout, Negative, Zero, Overflow, out_valid, step count and multiplier registers all go to 0.
  - in_ready is forced 0 while rst=1.
  - Reset during BUSY or DONE aborts the op; no out_valid is produced for it.
- out_ready is ignored when out_valid=0.

Test Plan:
- WIDTH=32, ADD A=0x7FFFFFFF, B=1, Cin=0 -> next cycle out_valid=1, Y=0x80000000, Overflow=1, Negative=1, Cout=0, Zero=0.
- SUB A=5, B=5 -> Y=0, Zero=1, Cout=1, Overflow=0. ADD 0xFFFFFFFF+0 with Cin=1 -> Y=0, Cout=1, Zero=1.
- MUL A=0x00010000, B=0x00010000 -> in_ready=0 for 32 cycles, out_valid rises exactly 33 cycles after accept, Y=0, Zero=1, Overflow=1. MUL 7*6 -> Y=42, Overflow=0.
- SRA A=0x80000000, B=31 -> Y=0xFFFFFFFF, Negative=1. SLL A=1, B=0x25 (amount 5) -> Y=0x20. SLT A=0xFFFFFFFF, B=1 -> Y=1.
- Hold out_ready=0 for 5 cycles after a result -> Y/flags stable, in_ready=0. Raise out_ready -> IDLE next cycle, next op accepted.
- Assert rst at MUL step 10 -> next cycle out_valid=0, Y=0, state IDLE. in_ready=1 once rst drops. Repeat a subset with WIDTH=8 (e.g. MUL 16*16 -> Y=0, Overflow=1, latency 9).
